// File: rtl/envelope_pkg.sv
// Shared types and helpers for the envelope follower: FSM states, the
// default accumulator fraction and the smoothing step rule.
package envelope_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int ACC_FRAC_DEF = 8;

    // One smoothing step toward the target: diff >>> shift, but never zero
    // while diff is nonzero, so the accumulator always lands exactly on target.
    function automatic logic signed [31:0] env_step(input logic signed [31:0] diff,
                                                    input logic [3:0]         shift);
        logic signed [31:0] step;
        step = diff >>> shift;
        if (step == 32'sd0 && diff != 32'sd0) begin
            step = (diff < 32'sd0) ? -32'sd1 : 32'sd1;
        end
        return step;
    endfunction

endpackage

// File: rtl/abs_sat.sv
// Stage 1 of the envelope follower: registered saturating magnitude of the
// signed input sample, truncated to the envelope width.
module abs_sat
    import envelope_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ENV_W = 9
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_i,
    output logic                 valid_o,
    output logic [ENV_W-1:0]     mag_o
);

    localparam logic signed [DW-1:0] MIN_S = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_S = {1'b0, {(DW-1){1'b1}}};

    logic             valid_q, valid_d;
    logic [ENV_W-1:0] mag_q, mag_d;
    logic [DW-1:0]    abs_v;

    // Magnitude with the most negative code clamped, then keep the top ENV_W
    // bits below the sign position.
    always_comb begin
        abs_v = data_i;
        if (data_i == MIN_S) begin
            abs_v = MAX_S;
        end else if (data_i[DW-1]) begin
            abs_v = -data_i;
        end
        mag_d   = ENV_W'(abs_v >> (DW - 1 - ENV_W));
        valid_d = valid_i;
    end

    // Stage-1 pipeline register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_q <= 1'b0;
            mag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mag_q   <= mag_d;
        end
    end

    assign valid_o = valid_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: recovers a 9-bit gain envelope from audio with attack,
// hold and release ballistics, plus a hysteretic noise-gate flag.
module envelope_follower
    import envelope_pkg::*;
#(
    parameter int DW           = 16,
    parameter int ENV_W        = 9,
    parameter int ACC_FRAC     = ACC_FRAC_DEF,
    parameter int HOLD_SAMPLES = 64
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 sample_tick_i,
    input  logic                 enable_i,
    input  logic signed [DW-1:0] data_i,
    input  logic [3:0]           attack_shift_i,
    input  logic [3:0]           release_shift_i,
    input  logic [ENV_W-1:0]     threshold_i,
    output logic [ENV_W-1:0]     env_o,
    output logic                 env_valid_o,
    output logic                 gate_o
);

    localparam int ACC_W = ENV_W + ACC_FRAC;
    localparam int HCW   = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

    logic             s1_valid;
    logic [ENV_W-1:0] s1_mag;
    logic [ACC_W-1:0] tgt;

    logic [ACC_W-1:0] acc_q, acc_d;
    env_state_t       state_q, state_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             gate_q, gate_d;

    logic signed [ACC_W:0] diff;
    logic                  rises;
    logic [ACC_W-1:0]      acc_att, acc_rel;
    logic [ENV_W-1:0]      env_next;

    abs_sat #(
        .DW    (DW),
        .ENV_W (ENV_W)
    ) u_abs_sat (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .valid_i  (sample_tick_i),
        .data_i   (data_i),
        .valid_o  (s1_valid),
        .mag_o    (s1_mag)
    );

    assign tgt = {s1_mag, {ACC_FRAC{1'b0}}};

    // Candidate accumulator values for an attack step and a release step.
    always_comb begin
        diff    = $signed({1'b0, tgt}) - $signed({1'b0, acc_q});
        rises   = tgt > acc_q;
        acc_att = acc_q + ACC_W'(env_step(32'(diff), attack_shift_i));
        acc_rel = acc_q + ACC_W'(env_step(32'(diff), release_shift_i));
    end

    // Ballistics FSM, accumulator and gate update on each stage-2 valid.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_d    = acc_q;
        state_d  = state_q;
        hold_d   = hold_q;
        gate_d   = gate_q;
        valid_d  = s1_valid;
        env_next = '0;
        if (!enable_i) begin
            acc_d   = '0;
            state_d = IDLE;
            hold_d  = '0;
            gate_d  = 1'b0;
        end else if (s1_valid) begin
            case (state_q)
                IDLE: begin
                    if (rises) begin
                        state_d = ATTACK;
                        acc_d   = acc_att;
                    end
                end
                ATTACK: begin
                    if (rises) begin
                        acc_d = acc_att;
                    end else if (HOLD_SAMPLES == 0) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HCW'(HOLD_SAMPLES);
                    end
                end
                HOLD: begin
                    if (rises) begin
                        state_d = ATTACK;
                        acc_d   = acc_att;
                    end else begin
                        hold_d = hold_q - HCW'(1);
                        if (hold_q <= HCW'(1)) begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rises) begin
                        state_d = ATTACK;
                        acc_d   = acc_att;
                    end else begin
                        acc_d = acc_rel;
                        if (acc_rel == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            endcase
            env_next = acc_d[ACC_W-1 -: ENV_W];
            if (env_next >= threshold_i) begin
                gate_d = 1'b1;
            end else if (env_next < (threshold_i >> 1)) begin
                gate_d = 1'b0;
            end
        end
    end

    // Stage-2 state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc_q   <= '0;
            state_q <= IDLE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            gate_q  <= gate_d;
        end
    end

    assign env_o       = acc_q[ACC_W-1 -: ENV_W];
    assign env_valid_o = valid_q;
    assign gate_o      = gate_q;

endmodule
